// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared helpers for the conv_mac_pipe MAC slice.
//   widths_legal : elaboration-time legality of the depth/width parameters
//   sat_max/min  : signed saturation limits for a result of width w
package conv_mac_pkg;

  localparam int MAX_STAGE = 6;

  function automatic bit widths_legal(input int id, input int num_stage,
                                      input int w0, input int w1,
                                      input int wacc, input int wout);
    return (id >= 0) && (num_stage >= 1) && (num_stage <= MAX_STAGE) &&
           (wacc >= w0 + w1) && (wout >= 2) && (wout <= wacc) && (wacc <= 63);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_mac_mul_pipe.sv
// conv_mac_mul_pipe: signed a*b multiplier followed by NUM_STAGE-1 extra
// registers (NUM_STAGE total), written so synthesis can pull the registers
// into a DSP block. No reset: validity is tracked by the caller's sideband.
//   clk, ce : clock and clock enable
//   a, b    : signed operands
//   p       : full-width signed product, NUM_STAGE ce-cycles after a/b
module conv_mac_mul_pipe #(
  parameter int NUM_STAGE = 3,
  parameter int A_W       = 8,
  parameter int B_W       = 16
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  output logic signed [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] stage_q [NUM_STAGE];

  always_ff @(posedge clk) begin
    if (ce) begin
      stage_q[0] <= a * b;
      for (int i = 1; i < NUM_STAGE; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign p = stage_q[NUM_STAGE-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined signed multiply-accumulate over framed windows.
// One beat per ce-cycle; one saturated/truncated result per window.
//   clk, reset (sync, active-high), ce (global hold)
//   in_valid/in_first/in_last, din0 (weight), din1 (activation) : beat
//   dout, out_valid, overflow : window result, one ce-cycle pulse
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int dout_WIDTH = 24,
  parameter bit SAT        = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_valid,
  output logic                         overflow
);

  localparam int P_W = din0_WIDTH + din1_WIDTH;
  localparam logic signed [dout_WIDTH-1:0] DOUT_MAX = dout_WIDTH'(sat_max(dout_WIDTH));
  localparam logic signed [dout_WIDTH-1:0] DOUT_MIN = dout_WIDTH'(sat_min(dout_WIDTH));

  if (!widths_legal(ID, NUM_STAGE, din0_WIDTH, din1_WIDTH, ACC_WIDTH, dout_WIDTH)) begin : g_illegal
    $error("conv_mac_pipe: illegal NUM_STAGE/width parameters");
  end

  logic signed [P_W-1:0]        p_mul;
  logic signed [ACC_WIDTH-1:0]  p_ext;
  logic [NUM_STAGE-1:0]         vld_q, fst_q, lst_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         done_q;
  logic signed [dout_WIDTH-1:0] dout_q, conv_d, low;
  logic                         out_valid_q, ovf_q, conv_ovf, fits;

  conv_mac_mul_pipe #(
    .NUM_STAGE (NUM_STAGE),
    .A_W       (din0_WIDTH),
    .B_W       (din1_WIDTH)
  ) u_mul (
    .clk (clk),
    .ce  (ce),
    .a   (din0),
    .b   (din1),
    .p   (p_mul)
  );

  assign p_ext = ACC_WIDTH'(p_mul);

  always_comb begin
    acc_d = acc_q;
    if (vld_q[NUM_STAGE-1]) begin
      acc_d = fst_q[NUM_STAGE-1] ? p_ext : acc_q + p_ext;
    end
  end

  // The result fits iff the bits above dout_WIDTH are a sign extension.
  always_comb begin
    low      = acc_q[dout_WIDTH-1:0];
    fits     = (ACC_WIDTH'(low) == acc_q);
    conv_d   = low;
    conv_ovf = !fits;
    if (SAT && !fits) begin
      conv_d = acc_q[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      fst_q       <= '0;
      lst_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      vld_q[0] <= in_valid;
      fst_q[0] <= in_first;
      lst_q[0] <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
        fst_q[i] <= fst_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      acc_q       <= acc_d;
      // done_q marks that acc_q now holds a finished window sum.
      done_q      <= vld_q[NUM_STAGE-1] & lst_q[NUM_STAGE-1];
      out_valid_q <= done_q;
      if (done_q) begin
        dout_q <= conv_d;
        ovf_q  <= conv_ovf;
      end
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
module tb_conv_mac_pipe;

  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [7:0]  din0;
  logic signed [15:0] din1;
  logic signed [23:0] dout_a;
  logic               outv_a, ovf_a;
  logic signed [15:0] dout_b;
  logic               outv_b, ovf_b;

  always #5 clk = ~clk;

  conv_mac_pipe #(
    .ID(0), .NUM_STAGE(NS), .din0_WIDTH(8), .din1_WIDTH(16),
    .ACC_WIDTH(32), .dout_WIDTH(24), .SAT(1'b1)
  ) dut_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .dout(dout_a), .out_valid(outv_a), .overflow(ovf_a)
  );

  conv_mac_pipe #(
    .ID(1), .NUM_STAGE(NS), .din0_WIDTH(8), .din1_WIDTH(16),
    .ACC_WIDTH(32), .dout_WIDTH(16), .SAT(1'b0)
  ) dut_trunc (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .dout(dout_b), .out_valid(outv_b), .overflow(ovf_b)
  );

  typedef struct {
    logic signed [23:0] d24;
    logic               o24;
    logic signed [15:0] d16;
    logic               o16;
    int                 cyc;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  int     ce_cnt = 0;
  longint macc   = 0;

  always @(posedge clk) if (ce) ce_cnt++;

  function automatic exp_t mk(input longint s);
    exp_t e;
    e.cyc = 0;
    if (s > 64'sd8388607) begin
      e.d24 = 24'sd8388607;
      e.o24 = 1'b1;
    end else if (s < -64'sd8388608) begin
      e.d24 = -24'sd8388608;
      e.o24 = 1'b1;
    end else begin
      e.d24 = 24'(s);
      e.o24 = 1'b0;
    end
    e.d16 = 16'(s);
    e.o16 = (s > 64'sd32767) || (s < -64'sd32768);
    return e;
  endfunction

  // Scoreboard: every qualified output pops one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ce && (outv_a || outv_b)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: dout_sat=%0d dout_trunc=%0d, no result expected", dout_a, dout_b);
      end else begin
        e = q.pop_front();
        checks += 6;
        if (outv_a !== 1'b1 || outv_b !== 1'b1) begin
          errors++;
          $display("FAIL out_valid_pair: sat=%b trunc=%b required 1/1", outv_a, outv_b);
        end
        if (dout_a !== e.d24) begin
          errors++;
          $display("FAIL dout_sat: got %0d required %0d", dout_a, e.d24);
        end
        if (ovf_a !== e.o24) begin
          errors++;
          $display("FAIL ovf_sat: got %b required %b", ovf_a, e.o24);
        end
        if (dout_b !== e.d16) begin
          errors++;
          $display("FAIL dout_trunc: got %0d required %0d", dout_b, e.d16);
        end
        if (ovf_b !== e.o16) begin
          errors++;
          $display("FAIL ovf_trunc: got %b required %b", ovf_b, e.o16);
        end
        if (ce_cnt !== e.cyc) begin
          errors++;
          $display("FAIL latency: result at ce-cycle %0d required %0d", ce_cnt, e.cyc);
        end
      end
    end
  end

  // Drives one beat (ce assumed high), updates the model, returns at posedge+1.
  task automatic beat(input bit v, input bit f, input bit l, input int w, input int a);
    exp_t   e;
    longint p;
    in_valid = v;
    in_first = f;
    in_last  = l;
    din0     = 8'(w);
    din1     = 16'(a);
    if (v) begin
      p    = longint'(w) * longint'(a);
      macc = f ? p : macc + p;
      macc = longint'(int'(macc));
      if (l) begin
        e     = mk(macc);
        e.cyc = ce_cnt + NS + 2;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", name, q.size());
      q.delete();
    end
    idle(3);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (outv_a !== 1'b0 || dout_a !== 24'sd0 || ovf_a !== 1'b0 ||
        outv_b !== 1'b0 || dout_b !== 16'sd0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL %s: sat v/d/o=%b/%0d/%b trunc v/d/o=%b/%0d/%b required all 0",
               name, outv_a, dout_a, ovf_a, outv_b, dout_b, ovf_b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    idle(3);
    reset = 1'b0;
    check_zero("reset_state");
  endtask

  task automatic test_no_first();
    beat(1, 0, 1, 7, -11);
    drain("no_first");
  endtask

  task automatic test_single();
    beat(1, 1, 1, -3, 1000);
    drain("single");
  endtask

  task automatic test_nine_term();
    for (int k = 1; k <= 9; k++) begin
      beat(1, k == 1, k == 9, k, 100);
      if (k == 3 || k == 6) beat(0, 0, 0, 0, 0);
    end
    drain("nine_term");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) beat(1, k == 0, k == 3, 127, 32767);
    for (int k = 0; k < 4; k++) beat(1, k == 0, k == 3, -128, 32767);
    drain("saturation");
  endtask

  task automatic test_restart();
    beat(1, 1, 0, 2, 3);
    beat(1, 0, 0, 4, 4);
    beat(1, 1, 1, 5, 5);
    drain("restart");
  endtask

  task automatic test_ce_freeze();
    int n;
    beat(1, 1, 0, 10, 20);
    beat(1, 0, 0, -5, 7);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
      din0 = 8'sd99; din1 = 16'sd999;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    ce = 1'b1;
    beat(1, 0, 1, 3, 3);
    drain("ce_mid_window");
    // Freeze while a result is on the outputs.
    beat(1, 1, 1, -9, 9);
    n = 0;
    while (outv_a !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (outv_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_wait: out_valid never rose, got %b required 1", outv_a);
    end
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (outv_a !== 1'b1 || dout_a !== -24'sd81 || dout_b !== -16'sd81) begin
        errors++;
        $display("FAIL ce_hold: v=%b dout_sat=%0d dout_trunc=%0d required 1/-81/-81",
                 outv_a, dout_a, dout_b);
      end
    end
    ce = 1'b1;
    drain("ce_hold");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) beat(1, 1, 1, (i + 1) * -7, i * 300 + 1);
    drain("back_to_back");
  endtask

  task automatic test_reset_inflight();
    beat(1, 1, 1, 4, 4);
    beat(1, 1, 1, 5, 5);
    beat(1, 1, 0, 6, 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    macc = 0;
    check_zero("reset_flush");
    idle(10);
    check_zero("reset_quiet");
    beat(1, 1, 1, 6, -6);
    drain("after_reset");
  endtask

  task automatic test_random();
    int len;
    for (int wdw = 0; wdw < 20; wdw++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        beat(1, k == 0, k == len - 1,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 65535)) - 32768);
        if ($urandom_range(0, 3) == 0) beat(0, 0, 0, 0, 0);
      end
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_no_first();
    test_single();
    test_nine_term();
    test_saturation();
    test_restart();
    test_ce_freeze();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_mac_pipe.md
# conv_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution datapath. It generalises the single-cycle signed 8x16 DSP multiplier into a configurable-width, configurable-depth MAC. It multiplies a weight by an activation each beat, accumulates over a framed kernel window, and emits one saturated result per window. It sits between the line-buffer/weight feed and the convolution output stage, and is the building block instantiated once per output channel.

## Interface
- ID, 1: instance identifier; no functional effect.
- NUM_STAGE, 3: multiplier pipeline depth in ce-cycles; legal range 1..6.
- din0_WIDTH, 8: signed weight width.
- din1_WIDTH, 16: signed activation width.
- ACC_WIDTH, 32: signed accumulator width; must be ≥ din0_WIDTH+din1_WIDTH.
- dout_WIDTH, 24: signed result width; must be ≤ ACC_WIDTH.
- SAT, 1: 1 = saturate the result to dout_WIDTH; 0 = truncate (keep the low dout_WIDTH bits).

Ports:
- clk  in  1  sole clock; all registers update on its rising edge.
- reset  in  1  synchronous, active-high; overrides ce.
- ce  in  1  clock enable; when low, every register holds.
- in_valid  in  1  beat qualifier for din0/din1/in_first/in_last.
- in_first  in  1  beat is the first term of a window.
- in_last  in  1  beat is the last term of a window.
- din0  in  din0_WIDTH  signed weight.
- din1  in  din1_WIDTH  signed activation.
- dout  out  dout_WIDTH  signed window result.
- out_valid  out  1  dout holds a new result.
- overflow  out  1  result was clipped (SAT=1) or lost bits (SAT=0); qualified by out_valid.

## Operation
- Multiplier: p = din0*din1, full signed width din0_WIDTH+din1_WIDTH, pipelined through NUM_STAGE registers.
- Sideband: valid, first and last travel in a shift register of the same NUM_STAGE depth, so they stay aligned with p.
- Accumulate stage, on an aligned valid beat:
  - first=1: acc <= sext(p).
  - otherwise: acc <= acc + sext(p), wrapping modulo 2^ACC_WIDTH.
- Aligned valid=0 (bubble): acc unchanged. Bubbles are legal anywhere inside a window.
- Output stage: when an aligned valid beat has last=1, the new sum (acc with this beat's term applied) is converted to dout_WIDTH and registered to dout, with out_valid=1 for that cycle.
- Conversion, SAT=1: if sum > 2^(dout_WIDTH-1)-1, dout = max and overflow=1. If sum < -2^(dout_WIDTH-1), dout = min and overflow=1. Otherwise dout = sum and overflow=0.
- Conversion, SAT=0: dout = sum[dout_WIDTH-1:0]; overflow=1 iff the discarded upper bits are not a sign extension.
- first and last on the same beat: the window has a single term, and the result equals p.
- first arriving while a window is open (no last seen): the open sum is discarded and a new window starts; no output.
- A valid beat with first=0 after reset: accumulates onto the reset value 0.
- After last, acc keeps the final sum until the next first.

## Timing
- Reset values: dout=0, out_valid=0, overflow=0, acc=0, all pipeline valid bits 0. Reset flushes every in-flight beat, and any partial window is lost.
- ce=0: the whole block freezes, including out_valid, dout and overflow. Downstream qualifies results with out_valid && ce.
- Latency: last beat accepted at ce-cycle t gives out_valid at ce-cycle t+NUM_STAGE+2 (NUM_STAGE multiplier stages, then the accumulate register, then the output register).
- Throughput: one beat per ce-cycle, with no back-pressure.
- Results: back-to-back one-term windows produce out_valid on consecutive ce-cycles.
- out_valid stays high for exactly one ce-enabled cycle per window.

## Structure
- Shared package conv_mac_pkg holds:
  - width-legality checks (elaboration-time assertions on ACC_WIDTH and dout_WIDTH);
  - the saturation limit constants, as functions of dout_WIDTH.
- Sub-module conv_mac_mul_pipe is the signed, DSP-inferable NUM_STAGE multiplier (ports clk, ce, a, b, p). It carries no reset on its data path; the top-level sideband carries validity.
- The top level contains the sideband shift register, the accumulator, and the saturate/output stage.

## Test plan
- Single-term window (first=last=1), din0=-3, din1=1000 -> after NUM_STAGE+2 cycles, dout=-3000, out_valid for 1 cycle, overflow=0.
- Nine-term window, weights 1..9 with all activations 100, bubbles inserted after terms 3 and 6 -> dout=4500; out_valid appears exactly once.
- Saturation, SAT=1, dout_WIDTH=24: 4 terms of 127*32767 -> sum 16,645,636 > 8,388,607, so dout=8,388,607 with overflow=1. The negative case (-128*32767 ×4) -> dout=-8,388,608.
- Restart: first, 2 terms, then a new first without last, then a 1-term last with 5*5 -> single result 25; the old partial sum is absent.
- ce held low 5 cycles mid-window, then released -> same result as the uninterrupted run, delayed by 5 cycles; outputs hold while ce=0.
- Reset asserted for 1 cycle while 2 windows are in flight -> no out_valid afterwards; all outputs 0; the next window produces a correct result.
